wb_stage: RTL and testbench

Writeback stage of the CPU pipeline, directly upstream of the register file write port. It accepts one retiring instruction per cycle from the execute/memory stage. ALU results pass straight through. Loads are held until the data memory responds, then the returned byte/half/word is extracted and extended. The stage drives the register file `we`/`adr_wrt`/`data_in` from registered outputs and never writes x0.

---
 rtl/wb_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly, holds loads until dmem_ack, then extracts/extends.
// Optional forwarding/hazard outputs are enabled with `define WB_BYPASS_EN.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [1:0]  ex_load_size,
    input  logic        ex_load_unsigned,
    input  logic [1:0]  ex_addr_lo,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_ready,
    output logic        rf_we,
    output logic [4:0]  rf_adr_wrt,
    output logic [31:0] rf_data_in,
    output logic        wb_err
`ifdef WB_BYPASS_EN
    ,
    output logic        byp_valid,
    output logic [4:0]  byp_rd,
    output logic [31:0] byp_data,
    output logic        ld_pend,
    output logic [4:0]  ld_pend_rd
`endif
);

    localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       lat_rd, lat_rd_nxt;
    logic [1:0]       lat_size, lat_size_nxt;
    logic             lat_uns, lat_uns_nxt;
    logic [1:0]       lat_alo, lat_alo_nxt;
    logic             we_nxt, err_nxt;
    logic [4:0]       adr_nxt;
    logic [31:0]      data_nxt;
    logic             xfer;
    logic             timeout_hit;

    assign wb_ready    = (state == IDLE) && !reset;
    assign xfer        = ex_valid && wb_ready;
    assign timeout_hit = (LOAD_TIMEOUT != 0) && (cnt == CNT_LAST);

    function automatic logic [31:0] extract(input logic [1:0] size, input logic uns,
                                            input logic [1:0] alo, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{alo, 3'b000} +: 8];
        h = w[{alo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // NOTE: async reset in the sensitivity list; all state uses non-blocking (<=) so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (xfer && ex_is_load) state_nxt = WAIT_LOAD;
            WAIT_LOAD: if (dmem_ack || timeout_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, otherwise the
    // branches that leave a signal unassigned would infer latches.
    always_comb begin
        we_nxt       = 1'b0;
        err_nxt      = 1'b0;
        adr_nxt      = rf_adr_wrt;
        data_nxt     = rf_data_in;
        cnt_nxt      = cnt;
        lat_rd_nxt   = lat_rd;
        lat_size_nxt = lat_size;
        lat_uns_nxt  = lat_uns;
        lat_alo_nxt  = lat_alo;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (ex_is_load) begin
                        lat_rd_nxt   = ex_rd;
                        lat_size_nxt = ex_load_size;
                        lat_uns_nxt  = ex_load_unsigned;
                        lat_alo_nxt  = ex_addr_lo;
                        cnt_nxt      = '0;
                    end else if (ex_rd != 5'd0) begin
                        // x0 writes are dropped entirely so address/data keep their last value
                        we_nxt   = 1'b1;
                        adr_nxt  = ex_rd;
                        data_nxt = ex_result;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_ack) begin
                    if (lat_rd != 5'd0) begin
                        we_nxt   = 1'b1;
                        adr_nxt  = lat_rd;
                        data_nxt = extract(lat_size, lat_uns, lat_alo, dmem_rdata);
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    err_nxt = timeout_hit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_adr_wrt <= 5'd0;
            rf_data_in <= 32'd0;
            wb_err     <= 1'b0;
            cnt        <= '0;
            lat_rd     <= 5'd0;
            lat_size   <= 2'd0;
            lat_uns    <= 1'b0;
            lat_alo    <= 2'd0;
        end else begin
            rf_we      <= we_nxt;
            rf_adr_wrt <= adr_nxt;
            rf_data_in <= data_nxt;
            wb_err     <= err_nxt;
            cnt        <= cnt_nxt;
            lat_rd     <= lat_rd_nxt;
            lat_size   <= lat_size_nxt;
            lat_uns    <= lat_uns_nxt;
            lat_alo    <= lat_alo_nxt;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid  = rf_we;
    assign byp_rd     = rf_adr_wrt;
    assign byp_data   = rf_data_in;
    assign ld_pend    = (state == WAIT_LOAD) && (lat_rd != 5'd0);
    assign ld_pend_rd = ld_pend ? lat_rd : 5'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table of ALU/load cases, a write scoreboard,
// and hand sequences for reset, back-to-back, stray ack and reset-during-load.
module tb_wb_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_result = '0;
    logic        ex_is_load = 1'b0;
    logic [1:0]  ex_load_size = '0;
    logic        ex_load_unsigned = 1'b0;
    logic [1:0]  ex_addr_lo = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_ready, rf_we, wb_err;
    logic [4:0]  rf_adr_wrt;
    logic [31:0] rf_data_in;
`ifdef WB_BYPASS_EN
    logic        byp_valid, ld_pend;
    logic [4:0]  byp_rd, ld_pend_rd;
    logic [31:0] byp_data;
`endif

    wb_stage #(.LOAD_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_is_load(ex_is_load), .ex_load_size(ex_load_size),
        .ex_load_unsigned(ex_load_unsigned), .ex_addr_lo(ex_addr_lo),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_ready(wb_ready), .rf_we(rf_we),
        .rf_adr_wrt(rf_adr_wrt), .rf_data_in(rf_data_in), .wb_err(wb_err)
`ifdef WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .ld_pend(ld_pend), .ld_pend_rd(ld_pend_rd)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  alo;
        logic [31:0] rdata;
        int          ack_dly;   // cycles after acceptance; 0 = never ack
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every observed register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(rf_we), 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_adr", 32'(rf_adr_wrt), 32'(w.rd));
                check("wr_data", rf_data_in, w.data);
`ifdef WB_BYPASS_EN
                check("byp_valid", 32'(byp_valid), 32'd1);
                check("byp_data", byp_data, w.data);
                check("byp_rd", 32'(byp_rd), 32'(w.rd));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wb_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 32'(wb_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int wcyc, last, rdy_at;
        wait_ready();
        ex_valid = 1'b1; ex_rd = v.rd; ex_result = v.result; ex_is_load = v.is_load;
        ex_load_size = v.size; ex_load_unsigned = v.uns; ex_addr_lo = v.alo;
        if (v.exp_we) exp_q.push_back('{v.rd, v.exp_data});
        if (!v.is_load)        wcyc = 1;
        else if (v.ack_dly == 0) wcyc = -1;
        else                   wcyc = v.ack_dly + 1;
        last   = (wcyc < 0) ? T + 1 : wcyc;
        rdy_at = !v.is_load ? 0 : (wcyc < 0 ? T + 1 : v.ack_dly + 1);
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            dmem_ack = 1'b0;
            if (v.is_load && v.ack_dly != 0 && k == v.ack_dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
            end
            check(k == wcyc ? "we_at_write" : "we_quiet", 32'(rf_we),
                  32'(k == wcyc ? v.exp_we : 1'b0));
            check("wb_err", 32'(wb_err), 32'(wcyc < 0 && k == T + 1));
            check("wb_ready", 32'(wb_ready), 32'(k >= rdy_at));
            if (v.exp_we && k == last + 1) begin
                check("adr_hold", 32'(rf_adr_wrt), 32'(v.rd));
                check("data_hold", rf_data_in, v.exp_data);
            end
`ifdef WB_BYPASS_EN
            if (v.is_load && k == 1) begin
                check("ld_pend", 32'(ld_pend), 32'(v.rd != 5'd0));
                check("ld_pend_rd", 32'(ld_pend_rd), 32'(v.rd));
            end
            if (v.is_load && k == rdy_at) check("ld_pend_clr", 32'(ld_pend), 32'd0);
`endif
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 5'd5,  32'h1234_5678, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b1, 32'h1234_5678};
        vecs[1]  = '{1'b0, 5'd0,  32'hAAAA_AAAA, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd7,  32'h0,         2'b00, 1'b0, 2'd2, 32'h1280_3456, 3, 1'b1, 32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 5'd8,  32'h0,         2'b01, 1'b1, 2'd2, 32'h1280_3456, 3, 1'b1, 32'h0000_1280};
        vecs[4]  = '{1'b1, 5'd9,  32'h0,         2'b10, 1'b0, 2'd1, 32'hDEAD_BEEF, 1, 1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 5'd10, 32'h0,         2'b00, 1'b1, 2'd0, 32'h0000_00F0, 2, 1'b1, 32'h0000_00F0};
        vecs[6]  = '{1'b1, 5'd11, 32'h0,         2'b01, 1'b0, 2'd1, 32'h1234_8001, 1, 1'b1, 32'hFFFF_8001};
        vecs[7]  = '{1'b1, 5'd0,  32'h0,         2'b00, 1'b0, 2'd3, 32'h7F00_0000, 2, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 5'd12, 32'h0,         2'b10, 1'b0, 2'd0, 32'h0,         0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 5'd13, 32'hCAFE_F00D, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b1, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 5'd14, 32'h0,         2'b11, 1'b0, 2'd2, 32'h0BAD_F00D, T, 1'b1, 32'h0BAD_F00D};
        vecs[11] = '{1'b1, 5'd15, 32'h0,         2'b00, 1'b0, 2'd1, 32'h0000_FF00, 2, 1'b1, 32'hFFFF_FFFF};

        // Reset held for three cycles: everything reads zero, then ready after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_we", 32'(rf_we), 32'd0);
            check("rst_adr", 32'(rf_adr_wrt), 32'd0);
            check("rst_data", rf_data_in, 32'd0);
            check("rst_err", 32'(wb_err), 32'd0);
            check("rst_ready", 32'(wb_ready), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(wb_ready), 32'd1);

        // Back-to-back ALU writes.
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd5; ex_result = 32'h1234_5678;
        exp_q.push_back('{5'd5, 32'h1234_5678});
        @(negedge clk);
        ex_rd = 5'd6; ex_result = 32'hFFFF_0000;
        exp_q.push_back('{5'd6, 32'hFFFF_0000});
        check("b2b_we1", 32'(rf_we), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("b2b_we2", 32'(rf_we), 32'd1);
        @(negedge clk);
        check("b2b_we_end", 32'(rf_we), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Ack while idle must not write.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_we", 32'(rf_we), 32'd0);

        // Reset during WAIT_LOAD, then a late ack after release.
        wait_ready();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd20; ex_load_size = 2'b10;
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_ready", 32'(wb_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(wb_ready), 32'd0);
        check("mid_rst_we", 32'(rf_we), 32'd0);
`ifdef WB_BYPASS_EN
        check("mid_rst_ld_pend", 32'(ld_pend), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(wb_ready), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        check("late_ack_we2", 32'(rf_we), 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
